// File: rtl/lsu_pkg.sv
// Load/store unit shared definitions.
// Holds the request size encodings, the FSM state enum, and the helpers
// that check alignment and place store data into its 32-bit byte lanes.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    BEAT0 = 3'd1,
    BEAT1 = 3'd2,
    WAIT  = 3'd3,
    RESP  = 3'd4
  } state_e;

  // Natural alignment: an access of 2^size bytes needs its low size bits clear.
  function automatic logic misaligned(size_e size, logic [2:0] low);
    case (size)
      SZ_H:    return low[0];
      SZ_W:    return |low[1:0];
      SZ_D:    return |low;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_strobe(size_e size, logic [1:0] offset);
    case (size)
      SZ_B:    return 4'b0001 << offset;
      SZ_H:    return offset[1] ? 4'b1100 : 4'b0011;
      default: return 4'hF;
    endcase
  endfunction

  // Right-aligned store data moved into its little-endian lanes; other lanes are 0.
  function automatic logic [31:0] store_lanes(size_e size, logic [1:0] offset, logic [31:0] data);
    case (size)
      SZ_B:    return {24'b0, data[7:0]} << {offset, 3'b000};
      SZ_H:    return offset[1] ? {data[15:0], 16'b0} : {16'b0, data[15:0]};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bus of the load/store unit.
//   req_valid/req_ready  request handshake
//   req_write            1 = store, 0 = load
//   req_size             B/H/W/D (lsu_pkg::size_e encoding)
//   req_unsigned         zero-extend load result
//   req_addr/req_wdata   byte address and right-aligned store data
//   resp_valid           one-cycle completion pulse
//   resp_err/resp_rdata  error flag and extended load data
// master = core/control path, slave = load_store_unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [63:0] resp_rdata;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_err, resp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_err, resp_rdata
  );
endinterface

// File: rtl/lsu_load_align.sv
// Load data extraction and extension (combinational).
//   raw          captured memory data; {hi, lo} for D, {32'b0, word} otherwise
//   size         access size
//   offset       byte address bits [1:0]
//   is_unsigned  zero-extend instead of sign-extend (ignored for D)
//   rdata        64-bit extended load result
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [63:0] raw,
  input  size_e       size,
  input  logic [1:0]  offset,
  input  logic        is_unsigned,
  output logic [63:0] rdata
);

  logic [31:0] word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    word     = raw[31:0];
    byte_sel = word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    rdata = is_unsigned ? {56'b0, byte_sel} : {{56{byte_sel[7]}}, byte_sel};
      SZ_H:    rdata = is_unsigned ? {48'b0, half_sel} : {{48{half_sel[15]}}, half_sel};
      SZ_W:    rdata = is_unsigned ? {32'b0, word} : {{32{word[31]}}, word};
      default: rdata = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the core and a synchronous-read 32-bit data array.
// Splits one B/H/W/D request into one or two 32-bit beats with byte strobes,
// checks alignment and range at accept, and returns extended load data.
//   clk, reset   clock and synchronous active-high reset
//   bus          core request/response (load_store_unit_if.slave)
//   mem_en/we    beat active / beat is a write
//   mem_addr     word index
//   mem_wstrb    write byte enables
//   mem_wdata    write data in its byte lanes
//   mem_rdata    read data, valid the cycle after a read beat
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  load_store_unit_if.slave  bus,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  state_e            state;
  logic              write_q;
  size_e             size_q;
  logic              unsigned_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_hi_q;
  logic [31:0]       lo_q;

  logic        accept;
  logic        req_error;
  logic [63:0] raw_capture;
  logic [63:0] aligned_rdata;

  assign accept    = bus.req_valid && bus.req_ready;
  assign req_error = misaligned(size_e'(bus.req_size), bus.req_addr[2:0]) ||
                     (|bus.req_addr[63:ADDR_W]);

  // In WAIT mem_rdata is the single word, or the high word of a D load.
  assign raw_capture = (size_q == SZ_D) ? {mem_rdata, lo_q} : {32'b0, mem_rdata};

  lsu_load_align u_align (
    .raw         (raw_capture),
    .size        (size_q),
    .offset      (addr_q[1:0]),
    .is_unsigned (unsigned_q),
    .rdata       (aligned_rdata)
  );

  // Memory outputs are registered, so they are loaded on the edge that enters
  // BEAT0/BEAT1 and fall back to 0 on every other edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      write_q        <= 1'b0;
      size_q         <= SZ_B;
      unsigned_q     <= 1'b0;
      addr_q         <= '0;
      wdata_hi_q     <= '0;
      lo_q           <= '0;
      bus.req_ready  <= 1'b1;
      bus.resp_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
      bus.resp_rdata <= '0;
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wstrb      <= '0;
      mem_wdata      <= '0;
    end else begin
      mem_en         <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wstrb      <= '0;
      mem_wdata      <= '0;
      bus.resp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            write_q        <= bus.req_write;
            size_q         <= size_e'(bus.req_size);
            unsigned_q     <= bus.req_unsigned;
            addr_q         <= bus.req_addr[ADDR_W-1:0];
            wdata_hi_q     <= bus.req_wdata[63:32];
            bus.req_ready  <= 1'b0;
            bus.resp_rdata <= '0;
            if (req_error) begin
              bus.resp_err   <= 1'b1;
              bus.resp_valid <= 1'b1;
              state          <= RESP;
            end else begin
              bus.resp_err <= 1'b0;
              mem_en       <= 1'b1;
              mem_we       <= bus.req_write;
              mem_addr     <= bus.req_addr[ADDR_W-1:2];
              if (bus.req_write) begin
                mem_wstrb <= store_strobe(size_e'(bus.req_size), bus.req_addr[1:0]);
                mem_wdata <= store_lanes(size_e'(bus.req_size), bus.req_addr[1:0],
                                         bus.req_wdata[31:0]);
              end
              state <= BEAT0;
            end
          end
        end
        BEAT0: begin
          if (size_q == SZ_D) begin
            mem_en   <= 1'b1;
            mem_we   <= write_q;
            mem_addr <= addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1);
            if (write_q) begin
              mem_wstrb <= 4'hF;
              mem_wdata <= wdata_hi_q;
            end
            state <= BEAT1;
          end else if (write_q) begin
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        BEAT1: begin
          if (write_q) begin
            bus.resp_valid <= 1'b1;
            state          <= RESP;
          end else begin
            lo_q  <= mem_rdata;
            state <= WAIT;
          end
        end
        WAIT: begin
          bus.resp_rdata <= aligned_rdata;
          bus.resp_valid <= 1'b1;
          state          <= RESP;
        end
        RESP: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed testbench for load_store_unit.
// Models the 64 x 32-bit synchronous-read array, logs every memory beat, and
// compares latency, response fields and beat contents against hand-computed
// values. Prints one summary line: CHECKS <n> ERRORS <m>.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [3:0]        mem_wstrb;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata = '0;

  int checkCount = 0;
  int errorCount = 0;

  logic [31:0] memArray [0:63];

  typedef struct {
    logic        we;
    logic [5:0]  addr;
    logic [3:0]  strb;
    logic [31:0] data;
  } beat_t;
  beat_t beatLog[$];

  load_store_unit_if bus();

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wstrb (mem_wstrb),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    for (int i = 0; i < 64; i++) memArray[i] = '0;
  end

  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_wstrb[b]) memArray[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end else begin
        mem_rdata <= memArray[mem_addr];
      end
    end
  end

  always @(negedge clk) begin
    if (mem_en) beatLog.push_back('{mem_we, mem_addr, mem_wstrb, mem_wdata});
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [63:0] beatWord(logic we, logic [5:0] addr, logic [3:0] strb,
                                           logic [31:0] data);
    return {21'b0, we, addr, strb, data};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkBeat(input string tag, input int idx, input logic we,
                           input logic [5:0] addr, input logic [3:0] strb,
                           input logic [31:0] data);
    if (idx < beatLog.size())
      checkOutput(tag, beatWord(beatLog[idx].we, beatLog[idx].addr, beatLog[idx].strb,
                                beatLog[idx].data), beatWord(we, addr, strb, data));
    else
      checkOutput({tag, " count"}, 64'(beatLog.size()), 64'(idx + 1));
  endtask

  // Drives a request at a negedge and returns #1 after the accepting edge.
  task automatic applyStimulus(input string tag, input logic write, input logic [1:0] size,
                               input logic uns, input logic [63:0] addr,
                               input logic [63:0] wdata);
    bit ok;
    ok = 0;
    beatLog.delete();
    @(negedge clk);
    bus.req_write    = write;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    bus.req_valid    = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.req_ready) ok = 1;
      else @(negedge clk);
    end
    checkOutput({tag, " accepted"}, 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic waitResponse(input string tag, input int expLat, input logic expErr,
                              input logic [63:0] expData);
    int          lat;
    logic        err;
    logic [63:0] data;
    lat  = -1;
    err  = 1'bx;
    data = 'x;
    for (int i = 1; i <= 12 && lat < 0; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        lat  = i;
        err  = bus.resp_err;
        data = bus.resp_rdata;
      end
    end
    checkOutput({tag, " latency"}, 64'(lat), 64'(expLat));
    checkOutput({tag, " err"}, 64'(err), 64'(expErr));
    checkOutput({tag, " rdata"}, data, expData);
    @(negedge clk);
    checkOutput({tag, " pulse"}, 64'(bus.resp_valid), 64'd0);
  endtask

  task automatic doRequest(input string tag, input logic write, input logic [1:0] size,
                           input logic uns, input logic [63:0] addr, input logic [63:0] wdata,
                           input int expLat, input logic expErr, input logic [63:0] expData);
    applyStimulus(tag, write, size, uns, addr, wdata);
    waitResponse(tag, expLat, expErr, expData);
  endtask

  // Second request is held valid while the first load is in flight.
  task automatic busyTest();
    int          respCycle;
    int          readyCycle;
    logic [63:0] firstData;
    respCycle  = -1;
    readyCycle = -1;
    firstData  = '0;
    @(negedge clk);
    bus.req_write    = 1'b0;
    bus.req_size     = SZ_W;
    bus.req_unsigned = 1'b1;
    bus.req_addr     = 64'h10;
    bus.req_wdata    = '0;
    bus.req_valid    = 1'b1;
    checkOutput("busy first ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.req_size = SZ_B;
    bus.req_addr = 64'h13;
    for (int i = 1; i <= 12 && readyCycle < 0; i++) begin
      @(negedge clk);
      if (bus.resp_valid && respCycle < 0) begin
        respCycle = i;
        firstData = bus.resp_rdata;
      end
      if (bus.req_ready) readyCycle = i;
    end
    checkOutput("busy first resp cycle", 64'(respCycle), 64'd3);
    checkOutput("busy ready cycle", 64'(readyCycle), 64'd4);
    checkOutput("busy first rdata", firstData, 64'h0000_0000_80AD_BEEF);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    waitResponse("busy second", 3, 1'b0, 64'h80);
  endtask

  task automatic resetMidStoreTest();
    bit sawResp;
    sawResp = 0;
    applyStimulus("rst st_d", 1'b1, SZ_D, 1'b0, 64'h20, 64'hAAAA_AAAA_BBBB_BBBB);
    @(negedge clk);
    checkOutput("rst beat0", {mem_en, 58'(mem_addr)}, {1'b1, 58'd8});
    @(negedge clk);
    checkOutput("rst beat1", {mem_en, 58'(mem_addr)}, {1'b1, 58'd9});
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst ready", 64'(bus.req_ready), 64'd1);
    checkOutput("rst resp_valid", 64'(bus.resp_valid), 64'd0);
    checkOutput("rst mem_en", 64'(mem_en), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.resp_valid) sawResp = 1;
    end
    checkOutput("rst no resp", 64'(sawResp), 64'd0);
    checkOutput("rst word8", 64'(memArray[8]), 64'hBBBB_BBBB);
    doRequest("rst ld_wu", 1'b0, SZ_W, 1'b1, 64'h20, '0, 3, 1'b0, 64'h0000_0000_BBBB_BBBB);
  endtask

  initial begin
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = SZ_B;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset req_ready", 64'(bus.req_ready), 64'd1);
    checkOutput("reset resp", {62'b0, bus.resp_valid, bus.resp_err}, 64'd0);
    checkOutput("reset rdata", bus.resp_rdata, 64'd0);
    checkOutput("reset mem", {mem_en, mem_we, mem_addr, mem_wstrb, mem_wdata}, 64'd0);
    reset = 1'b0;

    doRequest("st_w", 1'b1, SZ_W, 1'b0, 64'h10, 64'hDEAD_BEEF, 2, 1'b0, 64'd0);
    checkBeat("st_w beat", 0, 1'b1, 6'd4, 4'hF, 32'hDEAD_BEEF);
    doRequest("ld_wu", 1'b0, SZ_W, 1'b1, 64'h10, '0, 3, 1'b0, 64'h0000_0000_DEAD_BEEF);
    checkBeat("ld_wu beat", 0, 1'b0, 6'd4, 4'h0, 32'h0);
    doRequest("ld_w", 1'b0, SZ_W, 1'b0, 64'h10, '0, 3, 1'b0, 64'hFFFF_FFFF_DEAD_BEEF);

    doRequest("st_b", 1'b1, SZ_B, 1'b0, 64'h13, 64'h80, 2, 1'b0, 64'd0);
    checkBeat("st_b beat", 0, 1'b1, 6'd4, 4'b1000, 32'h8000_0000);
    doRequest("ld_b", 1'b0, SZ_B, 1'b0, 64'h13, '0, 3, 1'b0, 64'hFFFF_FFFF_FFFF_FF80);
    doRequest("ld_bu", 1'b0, SZ_B, 1'b1, 64'h13, '0, 3, 1'b0, 64'h80);
    doRequest("ld_b1", 1'b0, SZ_B, 1'b0, 64'h11, '0, 3, 1'b0, 64'hFFFF_FFFF_FFFF_FFBE);
    doRequest("ld_hu", 1'b0, SZ_H, 1'b1, 64'h10, '0, 3, 1'b0, 64'hBEEF);
    doRequest("ld_h", 1'b0, SZ_H, 1'b0, 64'h12, '0, 3, 1'b0, 64'hFFFF_FFFF_FFFF_80AD);

    doRequest("st_h", 1'b1, SZ_H, 1'b0, 64'h16, 64'hCAFE, 2, 1'b0, 64'd0);
    checkBeat("st_h beat", 0, 1'b1, 6'd5, 4'b1100, 32'hCAFE_0000);
    doRequest("ld_h hi", 1'b0, SZ_H, 1'b0, 64'h16, '0, 3, 1'b0, 64'hFFFF_FFFF_FFFF_CAFE);

    doRequest("st_d", 1'b1, SZ_D, 1'b0, 64'h20, 64'h1122_3344_5566_7788, 3, 1'b0, 64'd0);
    checkBeat("st_d beat0", 0, 1'b1, 6'd8, 4'hF, 32'h5566_7788);
    checkBeat("st_d beat1", 1, 1'b1, 6'd9, 4'hF, 32'h1122_3344);
    doRequest("ld_d", 1'b0, SZ_D, 1'b0, 64'h20, '0, 4, 1'b0, 64'h1122_3344_5566_7788);
    checkBeat("ld_d beat0", 0, 1'b0, 6'd8, 4'h0, 32'h0);
    checkBeat("ld_d beat1", 1, 1'b0, 6'd9, 4'h0, 32'h0);

    doRequest("err ld_h", 1'b0, SZ_H, 1'b0, 64'h21, '0, 1, 1'b1, 64'd0);
    checkOutput("err ld_h beats", 64'(beatLog.size()), 64'd0);
    doRequest("err ld_w range", 1'b0, SZ_W, 1'b0, 64'h100, '0, 1, 1'b1, 64'd0);
    checkOutput("err ld_w beats", 64'(beatLog.size()), 64'd0);
    doRequest("err st_d", 1'b1, SZ_D, 1'b0, 64'h24, 64'h1, 1, 1'b1, 64'd0);
    checkOutput("err st_d beats", 64'(beatLog.size()), 64'd0);
    doRequest("err ld_b top", 1'b0, SZ_B, 1'b0, 64'h8000_0000_0000_0000, '0, 1, 1'b1, 64'd0);

    resetMidStoreTest();
    busyTest();

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
